// File: rtl/tpu_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tpu_tile_scheduler
//
// Sequences one matrix job over a systolic array as a grid of m x n tiles.
// For every tile it requests a weight load, waits for the weights to ripple
// through the array, holds compute for preload + K cycles, then waits for the
// array to report completion. Arithmetic flags, a drain timeout or an abort
// end the job in an error state that reports the cause.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   job handshake; accepted only while idle
//   cmd_m_tiles/n_tiles   tile grid size (either zero -> empty job)
//   cmd_k_len             compute cycles per tile
//   cmd_accumulate        accumulate mode for the whole job
//   abort                 cancel the running job
//   arr_load_weights      one-cycle weight-load request
//   arr_start_compute     compute-hold level
//   arr_accumulate        accumulate mode, valid only while computing
//   arr_done              array completion pulse
//   arr_overflow/underflow array arithmetic flags
//   tile_m/tile_n         current tile index
//   tile_done/job_done/job_error  one-cycle status pulses
//   err_code              00 none, 01 arithmetic, 10 timeout, 11 abort
//   busy_cycles           saturating count of non-idle cycles of the job
// -----------------------------------------------------------------------------
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for a command, cmd_ready high
//  LOADW  | one-cycle weight-load request for the current tile
//  WLOAD  | weights shifting in, ARRAY_SIZE+1 cycles
//  RUN    | compute held high for ARRAY_SIZE+k_len cycles
//  DRAIN  | waiting for arr_done, bounded by TIMEOUT cycles
//  NEXT   | tile finished, advance index or finish the job
//  ERR    | job failed, wait for arithmetic flags to clear
//
module tpu_tile_scheduler #(
    parameter int ARRAY_SIZE = 64,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 4 * ARRAY_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_m_tiles,
    input  logic [CNT_W-1:0] cmd_n_tiles,
    input  logic [CNT_W-1:0] cmd_k_len,
    input  logic             cmd_accumulate,
    input  logic             abort,
    output logic             arr_load_weights,
    output logic             arr_start_compute,
    output logic             arr_accumulate,
    input  logic             arr_done,
    input  logic             arr_overflow,
    input  logic             arr_underflow,
    output logic [CNT_W-1:0] tile_m,
    output logic [CNT_W-1:0] tile_n,
    output logic             tile_done,
    output logic             job_done,
    output logic             job_error,
    output logic [1:0]       err_code,
    output logic [31:0]      busy_cycles
);

    // The RUN timer is one bit wider than the K field so that the longest
    // preload + compute period cannot wrap.
    localparam int TMR_W = CNT_W + 1;
    localparam int DRN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] WLOAD_LD = TMR_W'(ARRAY_SIZE);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
    localparam logic [DRN_W-1:0] DRAIN_LD = DRN_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ARITH = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_WLOAD,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        err_cause_d;

    logic [CNT_W-1:0]  m_tiles_q;
    logic [CNT_W-1:0]  n_tiles_q;
    logic [CNT_W-1:0]  k_len_q;
    logic              acc_q;
    logic [CNT_W-1:0]  tile_m_q;
    logic [CNT_W-1:0]  tile_n_q;
    logic [TMR_W-1:0]  timer_q;
    logic [DRN_W-1:0]  drain_q;
    logic [1:0]        err_code_q;
    logic              err_pulse_q;
    logic              zero_done_q;
    logic [31:0]       busy_q;

    logic              accept;
    logic              cmd_zero;
    logic              arith;
    logic              timer_tc;
    logic              drain_tc;
    logic              last_n;
    logic              last_tile;
    logic              next_ok;
    logic              err_entry;
    logic [TMR_W-1:0]  run_ld;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign cmd_zero  = (cmd_m_tiles == '0) || (cmd_n_tiles == '0);
    assign arith     = arr_overflow | arr_underflow;
    assign timer_tc  = (timer_q == '0);
    assign drain_tc  = (drain_q == '0);
    assign last_n    = (tile_n_q == (n_tiles_q - CNT_ONE));
    assign last_tile = last_n && (tile_m_q == (m_tiles_q - CNT_ONE));
    // An abort seen in NEXT wins over the tile/job completion.
    assign next_ok   = (state_q == S_NEXT) && !abort;
    assign err_entry = (state_q != S_ERR) && (state_d == S_ERR);
    assign run_ld    = WLOAD_LD + {1'b0, k_len_q} - TMR_ONE;

    // ------------------------------------------------------------------
    // Next-state logic. The per-state transitions are resolved first, then
    // arithmetic and abort override them so the error priority falls out
    // of statement order: abort > arithmetic > timeout > arr_done.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        err_cause_d = ERR_NONE;

        case (state_q)
            S_IDLE: begin
                if (accept && !cmd_zero) begin
                    state_d = S_LOADW;
                end
            end
            S_LOADW: begin
                state_d = S_WLOAD;
            end
            S_WLOAD: begin
                if (timer_tc) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (timer_tc) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_tc) begin
                    state_d     = S_ERR;
                    err_cause_d = ERR_TMO;
                end else if (arr_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = last_tile ? S_IDLE : S_LOADW;
            end
            S_ERR: begin
                if (!arith) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (((state_q == S_RUN) || (state_q == S_DRAIN)) && arith) begin
            state_d     = S_ERR;
            err_cause_d = ERR_ARITH;
        end

        // Abort is ignored while idle and has nothing to add once in ERR.
        if ((state_q != S_IDLE) && (state_q != S_ERR) && abort) begin
            state_d     = S_ERR;
            err_cause_d = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Command capture and tile index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tiles_q <= '0;
            n_tiles_q <= '0;
            k_len_q   <= '0;
            acc_q     <= 1'b0;
            tile_m_q  <= '0;
            tile_n_q  <= '0;
        end else if (accept) begin
            m_tiles_q <= cmd_m_tiles;
            n_tiles_q <= cmd_n_tiles;
            k_len_q   <= cmd_k_len;
            acc_q     <= cmd_accumulate;
            tile_m_q  <= '0;
            tile_n_q  <= '0;
        end else if (next_ok && !last_tile) begin
            if (last_n) begin
                tile_n_q <= '0;
                tile_m_q <= tile_m_q + CNT_ONE;
            end else begin
                tile_n_q <= tile_n_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase timers: down-counters loaded one cycle before the timed state
    // and left there when they reach their terminal count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                S_LOADW: begin
                    timer_q <= WLOAD_LD;
                end
                S_WLOAD: begin
                    timer_q <= timer_tc ? run_ld : (timer_q - TMR_ONE);
                end
                S_RUN: begin
                    drain_q <= DRAIN_LD;
                    if (!timer_tc) begin
                        timer_q <= timer_q - TMR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (!drain_tc) begin
                        drain_q <= drain_q - DRN_ONE;
                    end
                end
                default: begin
                    timer_q <= timer_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status: error code, pulses, busy counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_code_q  <= ERR_NONE;
            err_pulse_q <= 1'b0;
            zero_done_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            err_pulse_q <= err_entry;
            zero_done_q <= accept && cmd_zero;

            if (accept) begin
                err_code_q <= ERR_NONE;
            end else if (err_entry) begin
                err_code_q <= err_cause_d;
            end

            if (accept) begin
                busy_q <= '0;
            end else if ((state_q != S_IDLE) && (busy_q != '1)) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign cmd_ready         = (state_q == S_IDLE);
    assign arr_load_weights  = (state_q == S_LOADW);
    assign arr_start_compute = (state_q == S_RUN);
    assign arr_accumulate    = (state_q == S_RUN) && acc_q;
    assign tile_m            = tile_m_q;
    assign tile_n            = tile_n_q;
    assign tile_done         = next_ok;
    // An empty job completes from IDLE; it can never overlap a NEXT pulse
    // or the ERR entry pulse.
    assign job_done          = (next_ok && last_tile) || zero_done_q;
    assign job_error         = err_pulse_q;
    assign err_code          = err_code_q;
    assign busy_cycles       = busy_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tpu_tile_scheduler
//
// Directed bench for tpu_tile_scheduler with ARRAY_SIZE=4, CNT_W=8 and the
// default timeout (16). Inputs change 1 time unit after a rising edge and the
// outputs are checked at that same point; pulse/level counts are gathered on
// the rising edge by a separate monitor.
// -----------------------------------------------------------------------------
module tb_tpu_tile_scheduler;

    localparam int AS = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_m_tiles;
    logic [CW-1:0] cmd_n_tiles;
    logic [CW-1:0] cmd_k_len;
    logic          cmd_accumulate;
    logic          abort;
    logic          arr_load_weights;
    logic          arr_start_compute;
    logic          arr_accumulate;
    logic          arr_done;
    logic          arr_overflow;
    logic          arr_underflow;
    logic [CW-1:0] tile_m;
    logic [CW-1:0] tile_n;
    logic          tile_done;
    logic          job_done;
    logic          job_error;
    logic [1:0]    err_code;
    logic [31:0]   busy_cycles;

    tpu_tile_scheduler #(
        .ARRAY_SIZE (AS),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_m_tiles       (cmd_m_tiles),
        .cmd_n_tiles       (cmd_n_tiles),
        .cmd_k_len         (cmd_k_len),
        .cmd_accumulate    (cmd_accumulate),
        .abort             (abort),
        .arr_load_weights  (arr_load_weights),
        .arr_start_compute (arr_start_compute),
        .arr_accumulate    (arr_accumulate),
        .arr_done          (arr_done),
        .arr_overflow      (arr_overflow),
        .arr_underflow     (arr_underflow),
        .tile_m            (tile_m),
        .tile_n            (tile_n),
        .tile_done         (tile_done),
        .job_done          (job_done),
        .job_error         (job_error),
        .err_code          (err_code),
        .busy_cycles       (busy_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_lw = 0, n_sc = 0, n_td = 0, n_jd = 0, n_je = 0, n_both = 0;
    int lw0, sc0, td0, jd0, je0;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (arr_load_weights)  n_lw++;
            if (arr_start_compute) n_sc++;
            if (tile_done)         n_td++;
            if (job_done)          n_jd++;
            if (job_error)         n_je++;
            if (job_done && job_error) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        lw0 = n_lw; sc0 = n_sc; td0 = n_td; jd0 = n_jd; je0 = n_je;
    endtask

    task automatic send(input logic [CW-1:0] m, input logic [CW-1:0] n,
                        input logic [CW-1:0] k, input logic acc);
        cmd_m_tiles    = m;
        cmd_n_tiles    = n;
        cmd_k_len      = k;
        cmd_accumulate = acc;
        cmd_valid      = 1'b1;
        step(1);
        cmd_valid      = 1'b0;
    endtask

    // Bounded wait for arr_start_compute to reach the wanted level.
    task automatic wait_run(input logic want);
        int t = 0;
        while (arr_start_compute !== want && t < 300) begin
            step(1);
            t++;
        end
        chk(want ? "wait_run_start" : "wait_run_end", 32'(arr_start_compute), 32'(want));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_m_tiles = '0; cmd_n_tiles = '0;
        cmd_k_len = '0; cmd_accumulate = 1'b0; abort = 1'b0; arr_done = 1'b0;
        arr_overflow = 1'b0; arr_underflow = 1'b0;
        step(2);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_load_w",    32'(arr_load_weights), 0);
        chk("rst_start",     32'(arr_start_compute), 0);
        chk("rst_err_code",  32'(err_code), 0);
        chk("rst_busy",      busy_cycles, 0);
        chk("rst_tile_m",    32'(tile_m), 0);
        rst_n = 1'b1;
        step(1);

        // abort is ignored while idle
        abort = 1'b1;
        step(2);
        chk("idle_abort_ready", 32'(cmd_ready), 1);
        chk("idle_abort_err",   32'(job_error), 0);
        chk("idle_abort_code",  32'(err_code), 0);
        abort = 1'b0;

        // single tile, k=8, accumulate, arr_done in the third DRAIN cycle
        snap();
        send(8'd1, 8'd1, 8'd8, 1'b1);
        chk("s1_load_w",   32'(arr_load_weights), 1);
        chk("s1_busy_clr", busy_cycles, 0);
        chk("s1_not_rdy",  32'(cmd_ready), 0);
        step(1);
        chk("s1_wload_lw", 32'(arr_load_weights), 0);
        chk("s1_wload_sc", 32'(arr_start_compute), 0);
        step(4);
        chk("s1_wload_end", 32'(arr_start_compute), 0);
        step(1);
        chk("s1_run_first", 32'(arr_start_compute), 1);
        chk("s1_run_acc",   32'(arr_accumulate), 1);
        step(11);
        chk("s1_run_last",  32'(arr_start_compute), 1);
        step(1);
        chk("s1_drain_sc",  32'(arr_start_compute), 0);
        chk("s1_drain_acc", 32'(arr_accumulate), 0);
        step(2);
        arr_done = 1'b1;
        step(1);
        arr_done = 1'b0;
        chk("s1_tile_done", 32'(tile_done), 1);
        chk("s1_job_done",  32'(job_done), 1);
        chk("s1_job_err",   32'(job_error), 0);
        chk("s1_busy_next", busy_cycles, 21);
        step(1);
        chk("s1_idle_rdy",  32'(cmd_ready), 1);
        chk("s1_busy",      busy_cycles, 22);
        chk("s1_jd_low",    32'(job_done), 0);
        chk("s1_n_lw",      n_lw - lw0, 1);
        chk("s1_n_sc",      n_sc - sc0, 12);
        chk("s1_n_td",      n_td - td0, 1);
        chk("s1_n_jd",      n_jd - jd0, 1);

        // 2 x 3 tiles, tile order and pulse counts
        snap();
        send(8'd2, 8'd3, 8'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_run(1'b1);
            chk("s2_acc_off", 32'(arr_accumulate), 0);
            wait_run(1'b0);
            arr_done = 1'b1;
            step(1);
            arr_done = 1'b0;
            chk("s2_tile_done", 32'(tile_done), 1);
            chk("s2_tile_m", 32'(tile_m), i / 3);
            chk("s2_tile_n", 32'(tile_n), i % 3);
            chk("s2_job_done", 32'(job_done), (i == 5) ? 1 : 0);
            step(1);
        end
        chk("s2_idle_rdy", 32'(cmd_ready), 1);
        chk("s2_hold_m",   32'(tile_m), 1);
        chk("s2_hold_n",   32'(tile_n), 2);
        chk("s2_n_lw",     n_lw - lw0, 6);
        chk("s2_n_td",     n_td - td0, 6);
        chk("s2_n_jd",     n_jd - jd0, 1);

        // overflow in RUN cycle 3, held two cycles
        snap();
        send(8'd1, 8'd1, 8'd8, 1'b0);
        wait_run(1'b1);
        step(2);
        arr_overflow = 1'b1;
        step(1);
        chk("s3_sc_drop",  32'(arr_start_compute), 0);
        chk("s3_job_err",  32'(job_error), 1);
        chk("s3_code",     32'(err_code), 1);
        chk("s3_no_done",  32'(job_done), 0);
        step(1);
        chk("s3_err_once", 32'(job_error), 0);
        chk("s3_in_err",   32'(cmd_ready), 0);
        arr_overflow = 1'b0;
        step(1);
        chk("s3_idle_rdy", 32'(cmd_ready), 1);
        chk("s3_code_hold", 32'(err_code), 1);
        chk("s3_n_je",     n_je - je0, 1);
        chk("s3_n_jd",     n_jd - jd0, 0);

        // arr_done never arrives
        send(8'd1, 8'd1, 8'd1, 1'b0);
        wait_run(1'b1);
        wait_run(1'b0);
        step(15);
        chk("s4_drain16_err", 32'(job_error), 0);
        chk("s4_drain16_rdy", 32'(cmd_ready), 0);
        step(1);
        chk("s4_tmo_err",  32'(job_error), 1);
        chk("s4_tmo_code", 32'(err_code), 2);
        step(1);
        chk("s4_idle_rdy", 32'(cmd_ready), 1);

        // underflow during DRAIN
        send(8'd1, 8'd1, 8'd1, 1'b0);
        wait_run(1'b1);
        wait_run(1'b0);
        arr_underflow = 1'b1;
        step(1);
        chk("s5u_err",  32'(job_error), 1);
        chk("s5u_code", 32'(err_code), 1);
        arr_underflow = 1'b0;
        step(1);
        chk("s5u_rdy",  32'(cmd_ready), 1);

        // abort together with overflow during RUN, then an empty job
        send(8'd1, 8'd1, 8'd8, 1'b1);
        wait_run(1'b1);
        abort = 1'b1;
        arr_overflow = 1'b1;
        step(1);
        chk("s5_code_abort", 32'(err_code), 3);
        chk("s5_job_err",    32'(job_error), 1);
        chk("s5_sc",         32'(arr_start_compute), 0);
        chk("s5_acc",        32'(arr_accumulate), 0);
        abort = 1'b0;
        arr_overflow = 1'b0;
        step(1);
        chk("s5_idle_rdy",   32'(cmd_ready), 1);
        chk("s5_code_hold",  32'(err_code), 3);
        snap();
        send(8'd0, 8'd5, 8'd3, 1'b1);
        chk("s6_code_clr",   32'(err_code), 0);
        chk("s6_job_done",   32'(job_done), 1);
        chk("s6_rdy",        32'(cmd_ready), 1);
        chk("s6_no_lw",      32'(arr_load_weights), 0);
        step(1);
        chk("s6_jd_low",     32'(job_done), 0);
        step(2);
        chk("s6_n_lw",       n_lw - lw0, 0);
        chk("s6_n_sc",       n_sc - sc0, 0);
        chk("s6_n_jd",       n_jd - jd0, 1);

        // reset asserted in the middle of RUN
        snap();
        send(8'd2, 8'd2, 8'd8, 1'b0);
        wait_run(1'b1);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("s7_rdy",    32'(cmd_ready), 1);
        chk("s7_sc",     32'(arr_start_compute), 0);
        chk("s7_lw",     32'(arr_load_weights), 0);
        chk("s7_busy",   busy_cycles, 0);
        chk("s7_code",   32'(err_code), 0);
        chk("s7_td",     32'(tile_done), 0);
        chk("s7_jd",     32'(job_done), 0);
        chk("s7_je",     32'(job_error), 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("s7_rdy_after", 32'(cmd_ready), 1);
        chk("s7_n_jd",   n_jd - jd0, 0);
        chk("s7_n_je",   n_je - je0, 0);

        chk("never_both_pulses", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
